// File: rtl/adder_pipe_bk_32b.sv
// Two-stage pipelined 32-bit add/subtract unit with valid/ready handshake.
// Also contains the Brent-Kung carry tree that the adder consumes.

module carry_tree_bk_32b (
    input  logic [31:0] prop_i,
    input  logic [31:0] gen_i,
    output logic [31:0] carry_o
);
    // Level 0 is the input, 1..5 the up-sweep, 6..9 the down-sweep.
    logic [31:0] g_lvl [0:9];
    logic [31:0] p_lvl [0:9];

    assign g_lvl[0] = gen_i;
    assign p_lvl[0] = prop_i;

    for (genvar l = 0; l < 5; l++) begin : g_up
        for (genvar i = 0; i < 32; i++) begin : g_bit
            if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_node
                assign g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][i-(2**l)]);
                assign p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][i-(2**l)];
            end else begin : g_pass
                assign g_lvl[l+1][i] = g_lvl[l][i];
                assign p_lvl[l+1][i] = p_lvl[l][i];
            end
        end
    end

    for (genvar k = 5; k < 9; k++) begin : g_down
        localparam int L = 8 - k;
        for (genvar i = 0; i < 32; i++) begin : g_bit
            if ((i >= (2 ** (L + 1))) && (((i + 1) % (2 ** (L + 1))) == (2 ** L))) begin : g_node
                assign g_lvl[k+1][i] = g_lvl[k][i] | (p_lvl[k][i] & g_lvl[k][i-(2**L)]);
                assign p_lvl[k+1][i] = p_lvl[k][i] & p_lvl[k][i-(2**L)];
            end else begin : g_pass
                assign g_lvl[k+1][i] = g_lvl[k][i];
                assign p_lvl[k+1][i] = p_lvl[k][i];
            end
        end
    end

    assign carry_o = g_lvl[9];

    logic unused_p;
    assign unused_p = ^p_lvl[9];
endmodule

module adder_pipe_bk_32b #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      a_i,
    input  logic [31:0]      b_i,
    input  logic             sub_i,
    input  logic             cin_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      sum_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic [TAG_W-1:0] tag_o
);
    logic             s1_valid_q;
    logic [31:0]      s1_a_q;
    logic [31:0]      s1_bx_q;
    logic             s1_c0_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q;
    logic [31:0]      s2_sum_q;
    logic             s2_carry_q;
    logic             s2_ovf_q;
    logic             s2_zero_q;
    logic             s2_neg_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic s2_load;
    logic s1_load;
    logic accept;

    assign s2_load    = s1_valid_q & (~s2_valid_q | out_ready_i);
    assign s1_load    = ~s1_valid_q | s2_load;
    assign in_ready_o = s1_load & ~flush_i;
    assign accept     = in_valid_i & in_ready_o;

    logic [31:0] prop;
    logic [31:0] gen;
    logic [31:0] gen_c;
    logic [31:0] carry;
    logic [31:0] sum;

    assign prop  = s1_a_q ^ s1_bx_q;
    assign gen   = s1_a_q & s1_bx_q;
    // Carry-in folded into bit 0 so the tree output is the true carry chain.
    assign gen_c = {gen[31:1], gen[0] | (prop[0] & s1_c0_q)};

    carry_tree_bk_32b u_carry_tree (
        .prop_i  (prop),
        .gen_i   (gen_c),
        .carry_o (carry)
    );

    assign sum = prop ^ {carry[30:0], s1_c0_q};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_bx_q    <= '0;
            s1_c0_q    <= 1'b0;
            s1_tag_q   <= '0;
        end else if (flush_i) begin
            s1_valid_q <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid_i;
            if (accept) begin
                s1_a_q   <= a_i;
                s1_bx_q  <= sub_i ? ~b_i : b_i;
                s1_c0_q  <= sub_i | cin_i;
                s1_tag_q <= tag_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_carry_q <= 1'b0;
            s2_ovf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_neg_q   <= 1'b0;
            s2_tag_q   <= '0;
        end else if (flush_i) begin
            s2_valid_q <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= 1'b1;
            s2_sum_q   <= sum;
            s2_carry_q <= carry[31];
            s2_ovf_q   <= carry[31] ^ carry[30];
            s2_zero_q  <= ~|sum;
            s2_neg_q   <= sum[31];
            s2_tag_q   <= s1_tag_q;
        end else if (out_ready_i) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign sum_o       = s2_sum_q;
    assign carry_o     = s2_carry_q;
    assign ovf_o       = s2_ovf_q;
    assign zero_o      = s2_zero_q;
    assign neg_o       = s2_neg_q;
    assign tag_o       = s2_tag_q;
endmodule
